// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synthesizer control front end and its consumers
// (oscillator divider lookup, waveshaper).
//   - keypad layout: 13 chromatic note keys, mode key, soundgen key
//   - note code type: 0 = silence, 1..13 = key index + 1
//   - waveform mode enum and its cyclic successor
//   - autoplay sequencer state enum and the fixed 16-step tune
// -----------------------------------------------------------------------------
package synth_pkg;

  localparam int NUM_NOTE_KEYS = 13;
  localparam int KEYPAD_W      = 15;
  localparam int MODE_KEY      = 13;
  localparam int SOUNDGEN_KEY  = 14;
  localparam int NOTE_W        = 4;
  localparam int TUNE_LEN      = 16;
  localparam int STEP_W        = 4;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [STEP_W-1:0] step_t;

  localparam note_t NOTE_SILENT = '0;

  typedef enum logic [1:0] {
    MODE_SAW     = 2'd0,
    MODE_TRI     = 2'd1,
    MODE_PULSE25 = 2'd2,
    MODE_SQUARE  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

  // Successor in the mode cycle; SQUARE wraps back to SAW.
  function automatic mode_e next_mode(input mode_e m);
    logic [1:0] v;
    v = m;
    v = v + 2'd1;
    return mode_e'(v);
  endfunction

  // Fixed autoplay tune: C major scale up to high C and back down.
  function automatic note_t tune_note(input step_t step);
    note_t n;
    case (step)
      4'd0:    n = 4'd1;
      4'd1:    n = 4'd3;
      4'd2:    n = 4'd5;
      4'd3:    n = 4'd6;
      4'd4:    n = 4'd8;
      4'd5:    n = 4'd10;
      4'd6:    n = 4'd12;
      4'd7:    n = 4'd13;
      4'd8:    n = 4'd13;
      4'd9:    n = 4'd12;
      4'd10:   n = 4'd10;
      4'd11:   n = 4'd8;
      4'd12:   n = 4'd6;
      4'd13:   n = 4'd5;
      4'd14:   n = 4'd3;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/note_prio_enc.sv
// -----------------------------------------------------------------------------
// note_prio_enc
// Combinational lowest-index priority encoder for the note keys. Produces a
// note code with a +1 offset so that 0 can mean "no key pressed".
// Also used by the oscillator divider lookup.
// Ports:
//   keys  in  NUM_NOTE_KEYS  note key levels, bit 0 = low C
//   note  out NOTE_W         0 = none, else 1 + index of lowest set bit
// -----------------------------------------------------------------------------
module note_prio_enc
  import synth_pkg::*;
(
  input  logic [NUM_NOTE_KEYS-1:0] keys,
  output note_t                    note
);

  // Scan from the top down so the lowest set index is the last to win.
  always_comb begin
    note = NOTE_SILENT;
    for (int i = NUM_NOTE_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) begin
        note = NOTE_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/keypad_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_ctrl
// Control front end for the synthesizer core. Samples the keypad, resolves one
// live note, cycles the waveform mode on the mode key and runs a fixed-tune
// autoplay sequencer started/aborted by the soundgen key. All outputs are
// registered and feed the oscillator and waveshaper.
// Parameters:
//   STEP_CYCLES  clock cycles per sequencer step (tone + gap), > GAP_CYCLES
//   GAP_CYCLES   silent cycles at the end of each step, >= 1
// Ports:
//   clk           in  1   system clock
//   n_rst         in  1   asynchronous active-low reset
//   en            in  1   global enable; low silences and aborts playback
//   keypad_i      in  15  [12:0] note keys, [13] mode key, [14] soundgen key
//   note_o        out 4   0 = silence, 1..13 = note code
//   mode_o        out 2   0 SAW, 1 TRI, 2 PULSE25, 3 SQUARE
//   osc_rst_o     out 1   one-cycle pulse with every change of note_o
//   seq_active_o  out 1   high while the sequencer is not idle
// -----------------------------------------------------------------------------
module keypad_ctrl
  import synth_pkg::*;
#(
  parameter int STEP_CYCLES = 750000,
  parameter int GAP_CYCLES  = 75000
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic [KEYPAD_W-1:0] keypad_i,
  output logic [NOTE_W-1:0]   note_o,
  output logic [1:0]          mode_o,
  output logic                osc_rst_o,
  output logic                seq_active_o
);

  localparam int CNT_W = $clog2(STEP_CYCLES);

  // Terminal counts: cnt restarts at 0 on entry to TONE and to GAP.
  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(STEP_CYCLES - GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam step_t            LAST_STEP = step_t'(TUNE_LEN - 1);

  logic [KEYPAD_W-1:0] kp_q;
  seq_state_e          state_q, state_d;
  step_t               step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  note_t               note_q, note_d;
  mode_e               mode_q, mode_d;
  logic                osc_rst_q, osc_rst_d;

  logic [KEYPAD_W-1:0] rise;
  logic                rise_mode;
  logic                rise_sg;
  note_t               live_note;

  // Edge detect against last cycle's sample: a held key is one event.
  assign rise      = keypad_i & ~kp_q;
  assign rise_mode = rise[MODE_KEY];
  assign rise_sg   = rise[SOUNDGEN_KEY];

  note_prio_enc u_prio (
    .keys (keypad_i[NUM_NOTE_KEYS-1:0]),
    .note (live_note)
  );

  // Mode register is independent of the sequencer, so a simultaneous
  // mode/soundgen press is honoured by both.
  always_comb begin
    mode_d = mode_q;
    if (en && rise_mode) begin
      mode_d = next_mode(mode_q);
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    note_d  = note_q;

    if (!en) begin
      state_d = ST_IDLE;
      note_d  = NOTE_SILENT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_sg) begin
            state_d = ST_TONE;
            step_d  = '0;
            cnt_d   = '0;
            note_d  = tune_note('0);
          end else begin
            note_d  = live_note;
          end
        end

        ST_TONE: begin
          if (rise_sg) begin
            // Abort: fall straight back to live playing.
            state_d = ST_IDLE;
            note_d  = live_note;
          end else if (cnt_q == TONE_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            note_d  = NOTE_SILENT;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (rise_sg) begin
            state_d = ST_IDLE;
            note_d  = live_note;
          end else if (cnt_q == GAP_LAST) begin
            if (step_q == LAST_STEP) begin
              state_d = ST_IDLE;
              note_d  = live_note;
            end else begin
              state_d = ST_TONE;
              step_d  = step_q + step_t'(1);
              cnt_d   = '0;
              note_d  = tune_note(step_q + step_t'(1));
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          note_d  = NOTE_SILENT;
        end
      endcase
    end

    // Pulse lines up with the cycle in which the new note appears.
    osc_rst_d = (note_d != note_q);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      kp_q      <= '0;
      state_q   <= ST_IDLE;
      step_q    <= '0;
      cnt_q     <= '0;
      note_q    <= NOTE_SILENT;
      mode_q    <= MODE_SAW;
      osc_rst_q <= 1'b0;
    end else begin
      kp_q      <= keypad_i;
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      mode_q    <= mode_d;
      osc_rst_q <= osc_rst_d;
    end
  end

  assign note_o       = note_q;
  assign mode_o       = mode_q;
  assign osc_rst_o    = osc_rst_q;
  assign seq_active_o = (state_q != ST_IDLE);

endmodule

// File: doc/keypad_ctrl.md
# keypad_ctrl

Control front end for the synthesizer core. Samples the 15-bit keypad, resolves one active note, and cycles the waveform mode on the mode key. Runs a fixed-tune autoplay sequencer on the soundgen key. Its registered note/mode outputs drive the oscillator and waveshaper that produce the PWM audio output.

## Interface
- STEP_CYCLES, 750000: clock cycles per sequencer step (tone plus gap); must be > GAP_CYCLES.
- GAP_CYCLES, 75000: silent cycles at the end of each step (articulation); must be ≥ 1.
- clk  in  1  system clock (10 MHz)
- n_rst  in  1  reset, asynchronous, active-low
- en  in  1  global enable; low forces silence and aborts playback
- keypad_i  in  15  [12:0] note keys (bit 0 = low C … bit 12 = high C, chromatic), [13] mode key, [14] soundgen key; synchronous to clk
- note_o  out  4  0 = silence, 1..13 = note code (key index + 1)
- mode_o  out  2  0 SAW, 1 TRI, 2 PULSE25, 3 SQUARE
- osc_rst_o  out  1  one-cycle pulse coinciding with every change of note_o
- seq_active_o  out  1  high while sequencer state ≠ IDLE

## Operation
- Reset values: note_o=0, mode_o=0 (SAW), osc_rst_o=0, seq_active_o=0, state IDLE, key history register kp_q=0, step=0, cnt=0.
- Edge detect: kp_q ← keypad_i every cycle. rise[b] = keypad_i[b] & ~kp_q[b]. Holding a key yields one event.
- Mode: rise[13] with en=1 → mode_o ← mode_o+1 (mod 4, 3→0). Works in every state. Held across en=0; cleared only by reset.
- Live note (state IDLE, en=1): note_o ← 1 + index of lowest set bit of keypad_i[12:0]; 0 if none set.
- FSM states IDLE, TONE, GAP:
  - IDLE → TONE on rise[14] & en. step←0, cnt←0, note_o←TUNE[0].
  - TONE: cnt counts; when cnt = STEP_CYCLES−GAP_CYCLES−1 → GAP, cnt←0, note_o←0.
  - GAP: when cnt = GAP_CYCLES−1: step<15 → TONE, step←step+1, cnt←0, note_o←TUNE[step+1]; step=15 → IDLE, note_o←live note.
  - Any state: rise[14] while TONE/GAP → IDLE (abort). en=0 → IDLE, note_o←0.
- Note keys [12:0] are ignored in TONE/GAP.
- TUNE (16 × 4-bit): 1,3,5,6,8,10,12,13,13,12,10,8,6,5,3,1.
- osc_rst_o ← (next note_o ≠ current note_o), registered with note_o.
- Simultaneous rise[13] and rise[14] are both honoured in the same cycle. Simultaneous note keys resolve by lowest index.

## Timing
- All outputs are registered. A key sampled high at posedge N is reflected on outputs after posedge N. Latency is one edge.
- Sequencer step period = STEP_CYCLES exactly. Tone portion = STEP_CYCLES−GAP_CYCLES cycles, gap = GAP_CYCLES cycles. Full tune = 16·STEP_CYCLES cycles from the start edge to return to IDLE.
- cnt width = $clog2(STEP_CYCLES). Step counter is 4 bits, and wrap is never used (exit at 15).
- Reset mid-playback: all outputs return to reset values immediately (asynchronous). Playback does not resume.

## Structure
- synth_pkg: mode enum (SAW/TRI/PULSE25/SQUARE), note-code width, NUM_NOTE_KEYS=13, key bit positions (MODE_KEY=13, SOUNDGEN_KEY=14), TUNE constant array, FSM state enum.
- Sub-module note_prio_enc: combinational 13→4 lowest-index priority encoder with +1 offset and 0 for none. It is reused by the oscillator divider lookup.

## Test plan
Use STEP_CYCLES=8, GAP_CYCLES=2 unless noted.
- Reset: assert n_rst=0 mid-cycle → all outputs 0 without waiting for a clock edge. Release at negedge → still 0.
- Live note: en=1, keypad_i=15'h0001 → note_o=1 and osc_rst_o=1 for one cycle. Then 15'h1000 → note_o=13 plus a pulse. Then 15'h0101 → note_o=1. Then 0 → note_o=0.
- Mode: four single-cycle presses of bit 13, separated by release cycles → mode_o 1,2,3,0. Holding bit 13 for 10 cycles → increments once only.
- Sequencer: pulse bit 14 → seq_active_o=1.
  - note_o = 1 for 6 cycles, then 0 for 2 cycles, then 3 …
  - Finishes with 1, then 0, at cycle 128 after start; then IDLE and seq_active_o=0.
  - Note keys pressed during playback are ignored.
- Abort and enable: second bit-14 pulse at step 5 → IDLE, note_o follows live keys. Starting again then dropping en → note_o=0 and IDLE. mode_o is unchanged.
- Simultaneous: rise on bits 13 and 14 in the same cycle → mode increments and playback starts with TUNE[0]=1.
